// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   fetch_state_t : fetch FSM states (IDLE, REQ, HOLD, FAULT)
//   DEF_*         : default widths and wait limit
//   WAIT_W        : wait-counter width for the default MAX_WAIT
//   wait_width()  : wait-counter width for an arbitrary MAX_WAIT
package cpu_fetch_pkg;

  localparam int unsigned DEF_ADDR_W   = 10;
  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_MAX_WAIT = 15;
  localparam int unsigned WAIT_W       = $clog2(DEF_MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  function automatic int unsigned wait_width(input int unsigned max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/fetch_ras.sv
// Circular return-address stack.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : push i_data (when full, the oldest entry is overwritten)
//   i_pop          : discard the top entry (no effect when empty)
//   o_top          : current top entry (valid only when !o_empty)
//   o_empty, o_full: occupancy flags
// Pop takes priority if both requests arrive together.
module fetch_ras #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LP_LAST     = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] LP_FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;       // next free slot
  logic [CNT_W-1:0] r_cnt;      // live entries, saturates at DEPTH
  logic [PTR_W-1:0] w_top_idx;

  assign w_top_idx = (r_wr == '0) ? LP_LAST : r_wr - 1'b1;
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == LP_FULL_CNT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr  <= '0;
      r_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_pop) begin
      if (!o_empty) begin
        r_wr  <= w_top_idx;
        r_cnt <= r_cnt - 1'b1;
      end
    end else if (i_push) begin
      r_mem[r_wr] <= i_data;
      r_wr        <= (r_wr == LP_LAST) ? '0 : r_wr + 1'b1;
      if (!o_full) r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_fetch_seq.sv
// Instruction-fetch sequencer: PC, memory req/ready handshake, held
// instruction with valid/ack to decode, sticky wait-state timeout fault.
// Optional return-address stack enabled by defining CPU_FETCH_RAS_EN.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_stall                 : blocks launch of a new fetch
//   o_mem_req, o_mem_addr   : fetch request / address (= pc)
//   i_mem_ready, i_mem_rdata: memory data strobe / word
//   o_instr, o_instr_valid  : held instruction to decode
//   i_instr_ack             : decode consumed instruction
//   i_branch_en/_target     : redirect pc on ack
//   o_pc                    : address of current/held instruction
//   o_fault                 : sticky timeout fault (cleared by reset only)
//   i_call_en, i_ret_en     : (CPU_FETCH_RAS_EN only) call/return on ack
module cpu_fetch_seq
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEF_ADDR_W,
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       MAX_WAIT  = DEF_MAX_WAIT,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_instr,
  output logic              o_instr_valid,
  input  logic              i_instr_ack,
  input  logic              i_branch_en,
  input  logic [ADDR_W-1:0] i_branch_target,
`ifdef CPU_FETCH_RAS_EN
  input  logic              i_call_en,
  input  logic              i_ret_en,
`endif
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_fault
);

  localparam int unsigned LP_WAIT_W = wait_width(MAX_WAIT);
  // Counter value on the last permitted unanswered REQ cycle.
  localparam logic [LP_WAIT_W-1:0] LP_WAIT_LAST = LP_WAIT_W'(MAX_WAIT - 1);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("cpu_fetch_seq: MAX_WAIT must be in 1..255");
  end
  if (RAS_DEPTH < 1) begin : g_bad_ras_depth
    $error("cpu_fetch_seq: RAS_DEPTH must be at least 1");
  end

  fetch_state_t          r_state, w_state_nxt;
  logic [ADDR_W-1:0]     r_pc, w_pc_nxt, w_pc_seq;
  logic [DATA_W-1:0]     r_instr;
  logic                  r_instr_valid;
  logic                  r_fault;
  logic [LP_WAIT_W-1:0]  r_wait;
  logic                  w_accept, w_timeout, w_take;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_timeout   = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      IDLE: if (!i_stall) w_state_nxt = REQ;
      REQ: begin
        if (i_mem_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = HOLD;
        end else if (r_wait == LP_WAIT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = FAULT;
        end
      end
      HOLD: begin
        if (i_instr_ack) begin
          w_take      = 1'b1;
          w_state_nxt = i_stall ? IDLE : REQ;
        end
      end
      FAULT:   w_state_nxt = FAULT;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef CPU_FETCH_RAS_EN
  logic              w_push, w_pop, w_ras_empty, w_ras_full;
  logic [ADDR_W-1:0] w_ras_top;

  fetch_ras #(
    .WIDTH (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_seq),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty),
    .o_full  (w_ras_full)
  );
`endif

  // Next pc on ack; priority ret > call > branch > sequential.
  always_comb begin
    w_pc_seq = r_pc + 1'b1;
    w_pc_nxt = i_branch_en ? i_branch_target : w_pc_seq;
`ifdef CPU_FETCH_RAS_EN
    w_push = 1'b0;
    w_pop  = 1'b0;
    if (i_ret_en) begin
      w_pop    = w_take;
      w_pc_nxt = w_ras_empty ? RESET_PC : w_ras_top;
    end else if (i_call_en) begin
      w_push   = w_take;
      w_pc_nxt = i_branch_target;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
      r_wait        <= '0;
    end else begin
      if (w_accept) begin
        r_instr       <= i_mem_rdata;
        r_instr_valid <= 1'b1;
        r_wait        <= '0;
      end else if (r_state == REQ) begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_timeout) r_fault <= 1'b1;
      if (w_take) begin
        r_instr_valid <= 1'b0;
        r_pc          <= w_pc_nxt;
      end
    end
  end

  assign o_mem_req     = (r_state == REQ);
  assign o_mem_addr    = r_pc;
  assign o_pc          = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_fault       = r_fault;

endmodule

// File: tb/tb_cpu_fetch_seq.sv
// Scoreboard bench for cpu_fetch_seq: a driver issues randomized memory and
// decode traffic and pushes expected fetch addresses / instructions; a
// monitor pops and compares whenever the DUT starts a request or presents
// a new instruction.
module tb_cpu_fetch_seq;

  localparam int unsigned TB_MAX_WAIT = 15;
  localparam int unsigned TB_RAS_D    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ack = 1'b0;
  logic        branch_en = 1'b0;
  logic [9:0]  branch_target = '0;
  logic [9:0]  pc;
  logic        fault;
`ifdef CPU_FETCH_RAS_EN
  logic        call_en = 1'b0;
  logic        ret_en = 1'b0;
  logic [9:0]  ras_q[$];
`endif

  cpu_fetch_seq #(
    .ADDR_W   (10),
    .DATA_W   (16),
    .RESET_PC (10'd0),
    .MAX_WAIT (TB_MAX_WAIT),
    .RAS_DEPTH(TB_RAS_D)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_stall        (stall),
    .o_mem_req      (mem_req),
    .o_mem_addr     (mem_addr),
    .i_mem_ready    (mem_ready),
    .i_mem_rdata    (mem_rdata),
    .o_instr        (instr),
    .o_instr_valid  (instr_valid),
    .i_instr_ack    (instr_ack),
    .i_branch_en    (branch_en),
    .i_branch_target(branch_target),
`ifdef CPU_FETCH_RAS_EN
    .i_call_en      (call_en),
    .i_ret_en       (ret_en),
`endif
    .o_pc           (pc),
    .o_fault        (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int unsigned cyc;   // driver cycle in which ready was driven
    int unsigned run;   // expected number of mem_req cycles
  } exp_t;

  exp_t        exp_q[$];
  logic [9:0]  addr_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int          drv_mode = 0;  // 0 zero-wait, 1 random, 2 starve memory
  logic [9:0]  m_pc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Driver + reference model
  int unsigned wait_cnt = 0;
  int unsigned cur_delay = 0;
  logic [9:0]  nxt, tgt;
  logic        br;
  always @(negedge clk) begin
    if (mem_req) begin
      if (drv_mode != 2 && (drv_mode == 0 || wait_cnt >= cur_delay)) begin
        mem_ready = 1'b1;
        mem_rdata = (drv_mode == 0) ? 16'hA5A5 : 16'($urandom);
        exp_q.push_back('{data: mem_rdata, cyc: cyc, run: wait_cnt + 1});
        wait_cnt  = 0;
        cur_delay = $urandom_range(0, 4);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 16'($urandom);
        wait_cnt++;
      end
    end else begin
      wait_cnt  = 0;
      mem_ready = (drv_mode == 1) ? 1'($urandom) : (drv_mode == 0);
      mem_rdata = 16'($urandom);
    end

    stall = (drv_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
    tgt   = ($urandom_range(0, 3) == 0) ? 10'h3FF :
            ($urandom_range(0, 7) == 0) ? 10'h200 : 10'($urandom);
    br    = (drv_mode == 1) && ($urandom_range(0, 2) == 0);
    branch_target = tgt;
`ifdef CPU_FETCH_RAS_EN
    call_en = (drv_mode == 1) && ($urandom_range(0, 6) == 0);
    ret_en  = (drv_mode == 1) && ($urandom_range(0, 6) == 0);
`endif

    if (instr_valid && (drv_mode != 1 || $urandom_range(0, 1) == 1)) begin
      instr_ack = 1'b1;
      branch_en = br;
      nxt = br ? tgt : m_pc + 10'd1;
`ifdef CPU_FETCH_RAS_EN
      if (ret_en) begin
        nxt = (ras_q.size() != 0) ? ras_q.pop_back() : 10'd0;
      end else if (call_en) begin
        if (ras_q.size() == TB_RAS_D) void'(ras_q.pop_front());
        ras_q.push_back(m_pc + 10'd1);
        nxt = tgt;
      end
`endif
      addr_q.push_back(nxt);
      m_pc = nxt;
    end else begin
      // ack/branch without a held instruction must be ignored
      instr_ack = instr_valid ? 1'b0 : (drv_mode == 1) && 1'($urandom);
      branch_en = (drv_mode == 1) && 1'($urandom);
    end
  end

  // Monitor
  logic        prev_req = 1'b0, prev_valid = 1'b0;
  int unsigned run = 0, last_run = 0;
  logic [9:0]  cur_addr = '0;
  logic [15:0] held = '0;
  exp_t        e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
      prev_valid = 1'b0;
      run = 0;
    end else begin
      if (mem_req) run++;
      else if (run != 0) begin
        last_run = run;
        run = 0;
      end
      if (mem_req && !prev_req) begin
        if (addr_q.size() == 0) check("addr_queue_nonempty", 0, 1);
        else begin
          cur_addr = addr_q.pop_front();
          check("fetch_addr", 32'(mem_addr), 32'(cur_addr));
        end
        check("no_fault_on_req", 32'(fault), 0);
      end else if (mem_req) begin
        check("addr_stable", 32'(mem_addr), 32'(cur_addr));
      end
      if (instr_valid && !prev_valid) begin
        if (exp_q.size() == 0) check("instr_queue_nonempty", 0, 1);
        else begin
          e = exp_q.pop_front();
          held = e.data;
          check("instr", 32'(instr), 32'(e.data));
          check("valid_latency", cyc, e.cyc + 1);
          check("req_cycles", last_run, e.run);
        end
        check("pc_held", 32'(pc), 32'(cur_addr));
      end else if (instr_valid) begin
        check("instr_stable", 32'(instr), 32'(held));
        check("pc_stable", 32'(pc), 32'(cur_addr));
      end
      prev_req   = mem_req;
      prev_valid = instr_valid;
    end
  end

  initial begin
    int unsigned n;
    drv_mode = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_instr", 32'(instr), 0);
    repeat (3) @(negedge clk);
    addr_q.push_back(10'd0);
    m_pc  = 10'd0;
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", 32'(mem_req), 1);
    check("first_addr", 32'(mem_addr), 0);
    @(negedge clk);
    check("first_valid", 32'(instr_valid), 1);
    check("first_instr", 32'(instr), 32'h A5A5);

    drv_mode = 1;
    repeat (3000) @(negedge clk);

    drv_mode = 2;
    n = 0;
    while (!fault && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("fault_reached", 32'(fault), 1);
    @(negedge clk);
    check("timeout_req_cycles", last_run, TB_MAX_WAIT);
    repeat (20) begin
      @(negedge clk);
      check("fault_sticky", 32'(fault), 1);
      check("fault_no_req", 32'(mem_req), 0);
      check("fault_no_valid", 32'(instr_valid), 0);
    end
    check("addr_q_drained", addr_q.size(), 0);
    check("exp_q_drained", exp_q.size(), 0);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst2_fault", 32'(fault), 0);
    check("rst2_pc", 32'(pc), 0);
    check("rst2_mem_req", 32'(mem_req), 0);
    check("rst2_valid", 32'(instr_valid), 0);
    addr_q.delete();
    exp_q.delete();
`ifdef CPU_FETCH_RAS_EN
    ras_q.delete();
`endif
    m_pc = 10'd0;
    repeat (2) @(negedge clk);
    addr_q.push_back(10'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst2_first_req", 32'(mem_req), 1);
    check("rst2_first_addr", 32'(mem_addr), 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_fetch_seq.md
Name: cpu_fetch_seq

Overview:
Parametrised instruction-fetch sequencer. It is the next-generation replacement for the fixed 10-bit PC, +1 incrementer, PC mux and instruction-register path of the CPU top. It talks to instruction memory through a req/ready handshake, so wait-state memories and external RAM work without the old override generate. It presents a held instruction to decode with a valid/ack handshake and adds a wait-state timeout fault.

Parameters:
ADDR_W, 10, PC and memory address width
DATA_W, 16, instruction width
RESET_PC, 0, PC value loaded on reset
MAX_WAIT, 15, maximum cycles mem_req may stay unanswered before a fault (1..255)
RAS_DEPTH, 4, return-stack entries; used only when CPU_FETCH_RAS_EN is defined

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
stall  in  1  blocks launch of a new fetch
mem_req  out  1  fetch request to instruction memory
mem_addr  out  ADDR_W  fetch address (equals pc)
mem_ready  in  1  memory has data on mem_rdata this cycle
mem_rdata  in  DATA_W  fetched word
instr  out  DATA_W  held instruction
instr_valid  out  1  instr is valid for decode
instr_ack  in  1  decode consumed instr
branch_en  in  1  take branch_target on this ack
branch_target  in  ADDR_W  branch/jump destination
pc  out  ADDR_W  address of the current or held instruction
fault  out  1  sticky fetch-timeout fault

Behaviour:
- Reset values (reset low, asynchronous): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, mem_req=0, fault=0, wait counter=0, RAS empty.
- The states are IDLE, REQ, HOLD and FAULT.
- IDLE:
  - mem_req=0.
  - If stall=0, go to REQ next cycle.
  - The first request is therefore issued no earlier than 1 cycle after reset release.
- REQ:
  - mem_req=1, mem_addr=pc.
  - Once asserted, mem_req stays high until mem_ready, regardless of stall.
  - On mem_ready: instr<=mem_rdata, instr_valid<=1, wait counter cleared, go to HOLD.
  - Without mem_ready the wait counter increments. When it reaches MAX_WAIT with no ready: fault<=1, go to FAULT.
- Latency: mem_ready in the first REQ cycle gives instr_valid on the next edge. That is 1 cycle of request plus 1 to valid.
- HOLD:
  - instr and pc are stable while instr_valid=1 and instr_ack=0.
  - On instr_ack: instr_valid<=0, and pc updates.
    - If branch_en=1: pc<=branch_target.
    - Otherwise: pc<=pc+1, modulo 2^ADDR_W, so all-ones wraps to 0.
  - Then: if stall=0 go to REQ, else go to IDLE.
- branch_en is sampled only with instr_ack in HOLD and ignored elsewhere.
- instr_ack while instr_valid=0 is ignored.
- FAULT:
  - mem_req=0, instr_valid=0, fault=1.
  - Exits only on reset.
- Reset mid-transaction aborts the request immediately. Memory must tolerate mem_req dropping without ready.
- Branch and +1 arithmetic is unsigned ADDR_W-bit with no carry out.

Optional Feature:
CPU_FETCH_RAS_EN:
- When defined, adds call_en (in, 1) and ret_en (in, 1) and a RAS_DEPTH-entry return-address stack.
- Both inputs are sampled only with instr_ack.
- call_en: push pc+1 and load branch_target.
  - A push when the stack is full overwrites the oldest entry (circular).
- ret_en: pop into pc.
  - A pop when the stack is empty loads RESET_PC, with no fault.
- Priority: ret_en over call_en over branch_en.
- When the macro is undefined, the ports and stack are absent and the behaviour is exactly as above.

Decomposition:
- Package cpu_fetch_pkg holds:
  - the fetch_state_t enum {IDLE, REQ, HOLD, FAULT};
  - the localparam WAIT_W = $clog2(MAX_WAIT+1) helper;
  - default width constants (ADDR_W=10, DATA_W=16).
- One sub-module, fetch_ras: a circular stack with push/pop/empty/full, instantiated only under CPU_FETCH_RAS_EN.

Test Plan:
- Zero-wait fetch: reset release, stall=0, mem_ready tied 1, mem_rdata=16'hA5A5 → mem_req at cycle 1, mem_addr=0, instr_valid at cycle 2 with instr=A5A5. Ack → next mem_addr=1.
- Wait states: mem_ready delayed 3 cycles → mem_req held 4 cycles with mem_addr constant, and instr_valid rises exactly 1 cycle after ready.
- Branch: ack with branch_en=1, branch_target=10'h200 → next mem_addr=10'h200. A branch_en pulse outside HOLD → no pc change.
- Wrap: pc=10'h3FF, ack → next mem_addr=10'h000.
- Timeout: MAX_WAIT=15, mem_ready never asserted → fault=1 after 15 REQ cycles, mem_req=0 and it stays so until reset. Reset low → fault=0, pc=RESET_PC.
- RAS (macro on, RAS_DEPTH=4): call at pc=5 to 0x40, then ret → pc=6. Five nested calls then five rets → the last ret lands on the wrapped/overwritten entry per circular rule. Ret on empty → pc=RESET_PC.
